// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port negedge DataMemory between port A (CPU) and port B (DMA).
// Build option: DMEM_ARB_FIXED_PRIO_EN gives port A fixed priority; default is round-robin.
module dmem_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [31:0]       addr_a,
    input  logic [31:0]       addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              err_a,
    output logic              err_b,
    output logic              busy,
    output logic              mem_write,
    output logic [31:0]       mem_daddress,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int unsigned ADDR_W = 32;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state, state_d;
    logic                cur_b, cur_b_d;
    logic                cur_we, cur_we_d;
    logic                gnt_a_d, gnt_b_d, rvalid_a_d, rvalid_b_d, err_a_d, err_b_d;
    logic                busy_d, mem_write_d;
    logic [DATA_W-1:0]   rdata_a_d, rdata_b_d, mem_din_d;
    logic [ADDR_W-1:0]   mem_daddress_d;
    logic                pick_b, sel_we, in_range;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                rr_ptr, rr_ptr_d;  // 0 = A has priority, 1 = B
`endif

    // Winner selection and the winner's request fields
    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pick_b = req_b & ~req_a;
`else
        pick_b = req_b & (~req_a | rr_ptr);
`endif
        sel_we    = pick_b ? we_b    : we_a;
        sel_addr  = pick_b ? addr_b  : addr_a;
        sel_wdata = pick_b ? wdata_b : wdata_a;
        in_range  = sel_addr < ADDR_W'(DEPTH);
    end

    // Next state and next registered outputs
    always_comb begin
        state_d        = state;
        cur_b_d        = cur_b;
        cur_we_d       = cur_we;
        gnt_a_d        = 1'b0;
        gnt_b_d        = 1'b0;
        rvalid_a_d     = 1'b0;
        rvalid_b_d     = 1'b0;
        err_a_d        = 1'b0;
        err_b_d        = 1'b0;
        mem_write_d    = 1'b0;
        rdata_a_d      = rdata_a;
        rdata_b_d      = rdata_b;
        mem_daddress_d = mem_daddress;
        mem_din_d      = mem_din;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        rr_ptr_d       = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (req_a | req_b) begin
                    gnt_a_d = ~pick_b;
                    gnt_b_d = pick_b;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    rr_ptr_d = ~pick_b;
`endif
                    if (in_range) begin
                        mem_write_d    = sel_we;
                        mem_daddress_d = sel_addr;
                        mem_din_d      = sel_wdata;
                        cur_b_d        = pick_b;
                        cur_we_d       = sel_we;
                        state_d        = ISSUE;
                    end else begin
                        err_a_d = ~pick_b;
                        err_b_d = pick_b;
                    end
                end
            end
            ISSUE: begin
                // Memory acted on the mid-cycle negedge; capture its read data now
                if (!cur_we) begin
                    if (cur_b) begin
                        rdata_b_d  = mem_dout;
                        rvalid_b_d = 1'b1;
                    end else begin
                        rdata_a_d  = mem_dout;
                        rvalid_a_d = 1'b1;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ISSUE);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cur_b        <= 1'b0;
            cur_we       <= 1'b0;
            gnt_a        <= 1'b0;
            gnt_b        <= 1'b0;
            rvalid_a     <= 1'b0;
            rvalid_b     <= 1'b0;
            err_a        <= 1'b0;
            err_b        <= 1'b0;
            busy         <= 1'b0;
            mem_write    <= 1'b0;
            rdata_a      <= '0;
            rdata_b      <= '0;
            mem_daddress <= '0;
            mem_din      <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_ptr       <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            cur_b        <= cur_b_d;
            cur_we       <= cur_we_d;
            gnt_a        <= gnt_a_d;
            gnt_b        <= gnt_b_d;
            rvalid_a     <= rvalid_a_d;
            rvalid_b     <= rvalid_b_d;
            err_a        <= err_a_d;
            err_b        <= err_b_d;
            busy         <= busy_d;
            mem_write    <= mem_write_d;
            rdata_a      <= rdata_a_d;
            rdata_b      <= rdata_b_d;
            mem_daddress <= mem_daddress_d;
            mem_din      <= mem_din_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_ptr       <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural negedge DataMemory model.
module tb_dmem_arbiter;

    logic        clock, reset;
    logic        req_a, req_b, we_a, we_b;
    logic [31:0] addr_a, addr_b, wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, busy, mem_write;
    logic [31:0] rdata_a, rdata_b, mem_daddress, mem_din, mem_dout;
    logic [7:0]  flags;

    int nerr = 0;
    int nchk = 0;

    logic [31:0] mem [0:1023];

    dmem_arbiter #(.DATA_W(32), .DEPTH(1024)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .err_a(err_a), .err_b(err_b),
        .busy(busy), .mem_write(mem_write), .mem_daddress(mem_daddress),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DataMemory: acts on negedge
    always @(negedge clock) begin
        if (mem_write) mem[mem_daddress[9:0]] <= mem_din;
        mem_dout <= mem[mem_daddress[9:0]];
    end

    // {gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, busy, mem_write}
    assign flags = {gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, busy, mem_write};

    localparam logic [7:0] F_NONE  = 8'b0000_0000;
    localparam logic [7:0] F_GA_W  = 8'b1000_0011;
    localparam logic [7:0] F_GA_R  = 8'b1000_0010;
    localparam logic [7:0] F_GB_W  = 8'b0100_0011;
    localparam logic [7:0] F_GB_R  = 8'b0100_0010;
    localparam logic [7:0] F_RVA   = 8'b0010_0000;
    localparam logic [7:0] F_RVB   = 8'b0001_0000;
    localparam logic [7:0] F_ERRB  = 8'b0100_0100;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_dout = 32'h0;
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 32'h0; addr_b = 32'h0; wdata_a = 32'h0; wdata_b = 32'h0;

        // Reset state
        tick; tick;
        chk("reset_flags", 32'(flags), 32'(F_NONE));
        chk("reset_rdata_a", rdata_a, 32'h0);
        chk("reset_rdata_b", rdata_b, 32'h0);
        chk("reset_daddr", mem_daddress, 32'h0);
        chk("reset_din", mem_din, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("idle_flags", 32'(flags), 32'(F_NONE));
        end

        // A write DEADBEEF @5, then A read @5
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'd5; wdata_a = 32'hDEAD_BEEF;
        tick;
        chk("wr_a_gnt", 32'(flags), 32'(F_GA_W));
        chk("wr_a_daddr", mem_daddress, 32'd5);
        chk("wr_a_din", mem_din, 32'hDEAD_BEEF);
        req_a = 1'b0;
        tick;
        chk("wr_a_done", 32'(flags), 32'(F_NONE));
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'd5;
        tick;
        chk("rd_a_gnt", 32'(flags), 32'(F_GA_R));
        req_a = 1'b0;
        tick;
        chk("rd_a_rvalid", 32'(flags), 32'(F_RVA));
        chk("rd_a_rdata", rdata_a, 32'hDEAD_BEEF);
        tick;
        chk("rd_a_after", 32'(flags), 32'(F_NONE));
        chk("rd_a_hold", rdata_a, 32'hDEAD_BEEF);

        // Fresh reset so arbitration starts from port A
        reset = 1'b1;
        tick;
        reset = 1'b0;

        // Both ports hold read requests continuously
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'd5;
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'd5;
        for (int i = 0; i < 4; i++) begin
            logic exp_b;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_b = 1'b0;
`else
            exp_b = (i % 2) == 1;
`endif
            tick;
            chk("both_gnt", 32'(flags), exp_b ? 32'(F_GB_R) : 32'(F_GA_R));
            tick;
            chk("both_rvalid", 32'(flags), exp_b ? 32'(F_RVB) : 32'(F_RVA));
            chk("both_rdata", exp_b ? rdata_b : rdata_a, 32'hDEAD_BEEF);
        end
        req_a = 1'b0; req_b = 1'b0;
        tick;
        chk("both_idle", 32'(flags), 32'(F_NONE));

        // B read out of range
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'd1024;
        tick;
        chk("oor_b_err", 32'(flags), 32'(F_ERRB));
        chk("oor_b_daddr", mem_daddress, 32'd5);
        req_b = 1'b0;
        tick;
        chk("oor_b_after", 32'(flags), 32'(F_NONE));

        // B write 7 @6; A read @6 arrives during B's issue cycle
        req_b = 1'b1; we_b = 1'b1; addr_b = 32'd6; wdata_b = 32'd7;
        tick;
        chk("wr_b_gnt", 32'(flags), 32'(F_GB_W));
        chk("wr_b_daddr", mem_daddress, 32'd6);
        req_b = 1'b0;
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'd6;
        tick;
        chk("rd_a_wait", 32'(flags), 32'(F_NONE));
        tick;
        chk("rd_a6_gnt", 32'(flags), 32'(F_GA_R));
        req_a = 1'b0;
        tick;
        chk("rd_a6_rvalid", 32'(flags), 32'(F_RVA));
        chk("rd_a6_rdata", rdata_a, 32'd7);

        // Reset during ISSUE of an A read
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'd5;
        tick;
        chk("rst_mid_gnt", 32'(flags), 32'(F_GA_R));
        reset = 1'b1; req_a = 1'b0;
        tick;
        chk("rst_mid_flags", 32'(flags), 32'(F_NONE));
        chk("rst_mid_rdata", rdata_a, 32'h0);
        chk("rst_mid_daddr", mem_daddress, 32'h0);
        reset = 1'b0;
        tick;
        chk("rst_mid_norv", 32'(flags), 32'(F_NONE));
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'd5;
        tick;
        chk("post_rst_gnt", 32'(flags), 32'(F_GA_R));
        req_a = 1'b0;
        tick;
        chk("post_rst_rvalid", 32'(flags), 32'(F_RVA));
        chk("post_rst_rdata", rdata_a, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
